note_seq: RTL and testbench



---
 rtl/note_seq_pkg.sv | 62 ++++++
 rtl/note_seq_beat_timer.sv | 38 +++
 rtl/note_seq.sv | 127 ++++++++++++
 tb/tb_note_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// note_seq shared types, note/frequency tables and melody ROM.
// Used by note_seq and beat_timer.
package note_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  // ROM entry: {code[3:0], dur[2:0]}
  typedef logic [6:0] rom_t;

  localparam logic [3:0] N_REST = 4'd0;
  localparam logic [3:0] N_C4   = 4'd1;
  localparam logic [3:0] N_D4   = 4'd2;
  localparam logic [3:0] N_E4   = 4'd3;
  localparam logic [3:0] N_F4   = 4'd4;
  localparam logic [3:0] N_G4   = 4'd5;
  localparam logic [3:0] N_A4   = 4'd6;
  localparam logic [3:0] N_B4   = 4'd7;
  localparam logic [3:0] N_C5   = 4'd8;

  localparam int unsigned SONG_LEN = 16;

  // Hz per code; zero marks a rest
  localparam int unsigned FREQ [16] = '{
    0, 262, 294, 330, 349, 392, 440, 494,
    523, 0, 0, 0, 0, 0, 0, 0
  };

  localparam rom_t SONG [SONG_LEN] = '{
    {N_C4, 3'd1}, {N_C4, 3'd1},
    {N_G4, 3'd1}, {N_G4, 3'd1},
    {N_A4, 3'd1}, {N_A4, 3'd1},
    {N_G4, 3'd2}, {N_F4, 3'd1},
    {N_F4, 3'd1}, {N_E4, 3'd1},
    {N_E4, 3'd1}, {N_D4, 3'd1},
    {N_D4, 3'd1}, {N_C4, 3'd2},
    {N_REST, 3'd1}, {N_REST, 3'd1}
  };

  // Divide word for a note code; rests give 0 (silence)
  function automatic logic [31:0] div_of(
    input logic [3:0]  code,
    input int unsigned clk_hz
  );
    int unsigned f;
    f = FREQ[code];
    if (f == 0) return 32'd0;
    return clk_hz / f;
  endfunction

  // Indices past the ROM read as rests
  function automatic rom_t song_at(input logic [31:0] idx);
    if (idx >= SONG_LEN) return '0;
    return SONG[idx[3:0]];
  endfunction

endpackage

// File: rtl/note_seq_beat_timer.sv
// Beat counter 0..BEAT_CYC-1 with freeze and clear.
// tick_o pulses on the terminal count while enabled.
module beat_timer
  import note_seq_pkg::*;
#(
  parameter int BEAT_CYC = 12500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W =
    (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(BEAT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise wrap at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_seq.sv
// Melody sequencer feeding DIVN words to the tone divider.
// Define NOTE_SEQ_LOOP_EN to wrap to the first note instead of stopping.
module note_seq
  import note_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int          BEAT_CYC = 12500000,
  parameter int          NOTE_NUM = 16,
  localparam int IW = (NOTE_NUM > 1) ? $clog2(NOTE_NUM) : 1
) (
  input  logic          fin,
  input  logic          rst_n,
  input  logic          play,
  input  logic          restart,
  output logic [31:0]   DIVN,
  output logic          mute,
  output logic [IW-1:0] note_idx,
  output logic          done
);

  state_t        state_q;
  logic [31:0]   divn_q, shad_q;
  logic          mute_q, done_q;
  logic [IW-1:0] idx_q;
  logic [2:0]    left_q;

  rom_t        ent;
  logic [3:0]  code;
  logic [2:0]  dur1;
  logic [31:0] lut;
  logic        last;
  logic        tm_en, tm_clr, tick;

  assign ent  = song_at(32'(idx_q));
  assign code = ent[6:3];
  assign dur1 = (ent[2:0] == 3'd0) ? 3'd1 : ent[2:0];
  assign lut  = div_of(code, CLK_HZ);
  assign last = (idx_q == IW'(NOTE_NUM - 1));

  assign tm_en  = (state_q == S_PLAY) && play && !restart;
  assign tm_clr = (state_q == S_LOAD);

  beat_timer #(
    .BEAT_CYC(BEAT_CYC)
  ) u_beat (
    .clk_i (fin),
    .rst_ni(rst_n),
    .en_i  (tm_en),
    .clr_i (tm_clr),
    .tick_o(tick)
  );

  // Sequencer FSM with registered DIVN/mute/done
  always_ff @(posedge fin) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      divn_q  <= '0;
      shad_q  <= '0;
      mute_q  <= 1'b1;
      done_q  <= 1'b0;
      idx_q   <= '0;
      left_q  <= '0;
    end else if (restart) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (play) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
          end
        end
        S_LOAD: begin
          divn_q  <= lut;
          shad_q  <= lut;
          mute_q  <= (lut == 32'd0);
          left_q  <= dur1;
          state_q <= S_PLAY;
        end
        S_PLAY: begin
          if (!play) begin
            state_q <= S_PAUSE;
            divn_q  <= '0;
            mute_q  <= 1'b1;
          end else if (tick) begin
            left_q <= left_q - 3'd1;
            if (left_q == 3'd1) begin
              if (last) begin
`ifdef NOTE_SEQ_LOOP_EN
                state_q <= S_LOAD;
                idx_q   <= '0;
`else
                state_q <= S_DONE;
                divn_q  <= '0;
                mute_q  <= 1'b1;
                done_q  <= 1'b1;
`endif
              end else begin
                state_q <= S_LOAD;
                idx_q   <= idx_q + 1'b1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (play) begin
            state_q <= S_PLAY;
            divn_q  <= shad_q;
            mute_q  <= (shad_q == 32'd0);
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DIVN     = divn_q;
  assign mute     = mute_q;
  assign note_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_note_seq.sv
// Directed self-checking bench for note_seq (BEAT_CYC=4).
// Table-driven start-up vectors plus multi-cycle sequences.
module tb_note_seq;

  localparam int BEAT = 4;
  localparam int CLKH = 50000000;

  logic        fin = 1'b0;
  logic        rst_n = 1'b0;
  logic        play = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] DIVN;
  logic        mute, done;
  logic [3:0]  note_idx;

  int n_chk = 0;
  int n_pass = 0;

  // Hand-computed 50 MHz / f, truncated
  int unsigned exp_d [16] = '{
    190839, 190839, 127551, 127551,
    113636, 113636, 127551, 143266,
    143266, 151515, 151515, 170068,
    170068, 190839, 0, 0
  };
  int dur [16] = '{1,1,1,1,1,1,2,1,1,1,1,1,1,2,1,1};

  typedef struct {
    logic        rst_n;
    logic        play;
    logic        restart;
    logic [31:0] divn;
    logic        mute;
    logic [3:0]  idx;
    logic        done;
  } vec_t;

  vec_t vt [13];

  always #5 fin = ~fin;

  note_seq #(
    .CLK_HZ  (CLKH),
    .BEAT_CYC(BEAT),
    .NOTE_NUM(16)
  ) dut (
    .fin     (fin),
    .rst_n   (rst_n),
    .play    (play),
    .restart (restart),
    .DIVN    (DIVN),
    .mute    (mute),
    .note_idx(note_idx),
    .done    (done)
  );

  task automatic step();
    @(posedge fin);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] d,
    input logic        m,
    input logic [3:0]  i,
    input logic        dn
  );
    n_chk++;
    if (DIVN === d && mute === m && note_idx === i && done === dn)
      n_pass++;
    else
      $display("FAIL %s: got DIVN=%0d mute=%0b idx=%0d done=%0b, want DIVN=%0d mute=%0b idx=%0d done=%0b",
               nm, DIVN, mute, note_idx, done, d, m, i, dn);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    play = 1'b0;
    restart = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // start-up: reset, then play from IDLE
    vt[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,      1'b1, 4'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'd0,      1'b1, 4'd0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd1, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd1, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd1, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 32'd190839, 1'b0, 4'd2, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 32'd127551, 1'b0, 4'd2, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst_n   = vt[i].rst_n;
      play    = vt[i].play;
      restart = vt[i].restart;
      step();
      chk($sformatf("vec%0d", i), vt[i].divn, vt[i].mute,
          vt[i].idx, vt[i].done);
    end

    // full song with play held high
    do_reset();
    chk("song_reset", 32'd0, 1'b1, 4'd0, 1'b0);
    play = 1'b1;
    step();
    chk("song_load0", 32'd0, 1'b1, 4'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("song_n%0d_start", k), exp_d[k],
          exp_d[k] == 0, 4'(k), 1'b0);
      for (int j = 1; j < dur[k] * BEAT; j++) begin
        step();
        chk($sformatf("song_n%0d_hold", k), exp_d[k],
            exp_d[k] == 0, 4'(k), 1'b0);
      end
      step();
      if (k < 15)
        chk($sformatf("song_n%0d_next", k), exp_d[k],
            exp_d[k] == 0, 4'(k + 1), 1'b0);
    end
`ifdef NOTE_SEQ_LOOP_EN
    chk("loop_wrap", 32'd0, 1'b1, 4'd0, 1'b0);
    step();
    chk("loop_first", 32'd190839, 1'b0, 4'd0, 1'b0);
`else
    chk("song_done", 32'd0, 1'b1, 4'd15, 1'b1);
    for (int c = 0; c < 100; c++) begin
      step();
      chk("done_stay", 32'd0, 1'b1, 4'd15, 1'b1);
    end
    restart = 1'b1;
    step();
    chk("rs_done", 32'd0, 1'b1, 4'd0, 1'b0);
    restart = 1'b0;
    step();
    chk("rs_done_play", 32'd190839, 1'b0, 4'd0, 1'b0);
`endif

    // pause at beat count 2 of note 0
    do_reset();
    play = 1'b1;
    step();
    step();
    chk("p_start", 32'd190839, 1'b0, 4'd0, 1'b0);
    step();
    step();
    play = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("p_paused", 32'd0, 1'b1, 4'd0, 1'b0);
    end
    play = 1'b1;
    step();
    chk("p_resume", 32'd190839, 1'b0, 4'd0, 1'b0);
    step();
    chk("p_cnt3", 32'd190839, 1'b0, 4'd0, 1'b0);
    step();
    chk("p_end", 32'd190839, 1'b0, 4'd1, 1'b0);
    step();
    chk("p_n1", 32'd190839, 1'b0, 4'd1, 1'b0);
    play = 1'b0;
    step();
    chk("p_pause2", 32'd0, 1'b1, 4'd1, 1'b0);
    restart = 1'b1;
    step();
    chk("rs_pause", 32'd0, 1'b1, 4'd0, 1'b0);
    restart = 1'b0;
    play = 1'b1;
    step();
    chk("rs_pause_play", 32'd190839, 1'b0, 4'd0, 1'b0);

    // restart on the note-end tick, then reset mid-play
    do_reset();
    play = 1'b1;
    step();
    step();
    step();
    step();
    step();
    chk("t_cnt3", 32'd190839, 1'b0, 4'd0, 1'b0);
    restart = 1'b1;
    step();
    chk("t_restart", 32'd190839, 1'b0, 4'd0, 1'b0);
    restart = 1'b0;
    step();
    chk("t_replay", 32'd190839, 1'b0, 4'd0, 1'b0);
    step();
    step();
    step();
    step();
    chk("t_next", 32'd190839, 1'b0, 4'd1, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid", 32'd0, 1'b1, 4'd0, 1'b0);
    rst_n = 1'b1;
    play = 1'b0;
    step();
    chk("rst_idle", 32'd0, 1'b1, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
